// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core: widths, opcodes, fetch FSM states.
package core_pkg;

  localparam int XLEN = 16;

  localparam logic [4:0] OPC_HALT = 5'b00000;
  localparam logic [4:0] OPC_NOP  = 5'b00001;

  localparam logic [XLEN-1:0] NOP_INSTR = {OPC_NOP, 11'b0};
  localparam logic [XLEN-1:0] PC_RESET  = 16'h0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP,
    HALTED
  } fetch_state_t;

  // Wraps modulo 2^16 by construction of the return width.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush-to-NOP beats stall-hold, which beats load.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_plus2_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_plus2_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_plus2_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      instr_q    <= NOP;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else if (load_i && !hold_i) begin
      instr_q    <= instr_i;
      pc_plus2_q <= pc_plus2_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus2_o = pc_plus2_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one request outstanding to a variable-latency
// memory, buffers one word across decode stalls, and handles redirect/HALT flushes.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET  = core_pkg::PC_RESET,
  parameter logic [XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_dec,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_plus2,
  output logic            instr_valid,
  output logic            halted,
  output logic            err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            err_q, err_d;
  logic            halted_q, halted_d;

  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_instr;
  logic [XLEN-1:0] pc_next;

  assign pc_next = pc_inc(pc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= PC_RESET;
      hold_q   <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    err_d      = err_q;
    halted_d   = halted_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = imem_data;

    if (state_q != HALTED) begin
      if (redirect) begin
        pc_d       = {redirect_pc[XLEN-1:1], 1'b0};
        ifid_flush = 1'b1;
        if (redirect_pc[0]) err_d = 1'b1;
        // A request still in flight will return a word for the old PC; go discard it.
        if ((state_q == FETCH || state_q == DROP) && !imem_valid) state_d = DROP;
        else                                                      state_d = FETCH;
      end else if (halt_dec) begin
        state_d    = HALTED;
        halted_d   = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        case (state_q)
          FETCH: begin
            if (imem_valid) begin
              if (stall) begin
                hold_d  = imem_data;
                state_d = HOLD;
              end else begin
                ifid_load = 1'b1;
                pc_d      = pc_next;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              ifid_load  = 1'b1;
              ifid_instr = hold_q;
              pc_d       = pc_next;
              state_d    = FETCH;
            end
          end
          DROP: begin
            if (imem_valid) state_d = FETCH;
          end
          default: ;
        endcase
      end
    end
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ifid_load),
    .hold_i     (stall),
    .flush_i    (ifid_flush),
    .instr_i    (ifid_instr),
    .pc_plus2_i (pc_next),
    .instr_o    (instr),
    .pc_plus2_o (pc_plus2),
    .valid_o    (instr_valid)
  );

  assign imem_req  = (state_q == FETCH || state_q == DROP) && !rst;
  assign imem_addr = pc_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule
